// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix keypad front end: scanner states,
// operator-class codes and the 4x4 key lookup tables indexed by c*4 + r.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      PRESENT,
      WAIT_RELEASE
   } state_e;

   localparam logic [2:0] SIGN_NONE = 3'b000;
   localparam logic [2:0] SIGN_A    = 3'b001;
   localparam logic [2:0] SIGN_HASH = 3'b010;
   localparam logic [2:0] SIGN_BC   = 3'b011;
   localparam logic [2:0] SIGN_SUB  = 3'b100;

   localparam int SETTLE_W = 4;
   localparam int CNT_W    = 8;

   // Index = c*4 + r; row 0 is the bottom row (*, 0, #, D).
   localparam logic [3:0] KEY_VALUE_LUT [16] = '{
      4'h0, 4'h7, 4'h4, 4'h1,
      4'h0, 4'h8, 4'h5, 4'h2,
      4'h0, 4'h9, 4'h6, 4'h3,
      4'hF, 4'hC, 4'hB, 4'hA
   };

   localparam logic [2:0] KEY_SIGN_LUT [16] = '{
      SIGN_SUB,  SIGN_NONE, SIGN_NONE, SIGN_NONE,
      SIGN_NONE, SIGN_NONE, SIGN_NONE, SIGN_NONE,
      SIGN_HASH, SIGN_NONE, SIGN_NONE, SIGN_NONE,
      SIGN_SUB,  SIGN_BC,   SIGN_BC,   SIGN_A
   };

endpackage

// File: rtl/keypad_decode.sv
// Combinational key decoder: (column, row) -> key index, value nibble and operator class.
module keypad_decode
   import keypad_pkg::*;
#(
   parameter int ROWS = 4,
   parameter int COLS = 4
) (
   input  logic [$clog2(COLS)-1:0]      col_idx,
   input  logic [$clog2(ROWS)-1:0]      row_idx,
   output logic [$clog2(ROWS*COLS)-1:0] key_code,
   output logic [3:0]                   key_value,
   output logic [2:0]                   is_sign_key
);

   localparam int KEY_W = $clog2(ROWS*COLS);

   assign key_code = KEY_W'(col_idx) * KEY_W'(ROWS) + KEY_W'(row_idx);

   generate
      if (ROWS == 4 && COLS == 4) begin : g_map
         assign key_value   = KEY_VALUE_LUT[key_code];
         assign is_sign_key = KEY_SIGN_LUT[key_code];
      end else if (KEY_W >= 4) begin : g_wide
         assign key_value   = key_code[3:0];
         assign is_sign_key = SIGN_NONE;
      end else begin : g_narrow
         assign key_value   = 4'(key_code);
         assign is_sign_key = SIGN_NONE;
      end
   endgenerate

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: rotating column strobe, press/release debounce,
// ghost rejection and one held valid/ready transfer per physical press.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int ROWS           = 4,
   parameter int COLS           = 4,
   parameter int SETTLE_CYCLES  = 1,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic                         slow_clk,
   input  logic                         rst,
   input  logic [ROWS-1:0]              row_in,
   output logic [COLS-1:0]              col_drive,
   output logic                         key_valid,
   input  logic                         key_ready,
   output logic [$clog2(ROWS*COLS)-1:0] key_code,
   output logic [3:0]                   key_value,
   output logic [2:0]                   is_sign_key,
   output logic                         key_pressed
);

   localparam int COL_W = $clog2(COLS);
   localparam int ROW_W = $clog2(ROWS);
   localparam int KEY_W = $clog2(ROWS*COLS);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0]    DEB_TARGET  = CNT_W'(DEBOUNCE_SCANS);
   localparam logic [COL_W-1:0]    COL_LAST    = COL_W'(COLS - 1);

   state_e               state_q, state_d;
   logic [COL_W-1:0]     col_idx_q, col_idx_d;
   logic [COLS-1:0]      col_drive_q, col_drive_d;
   logic [ROW_W-1:0]     row_idx_q, row_idx_d;
   logic [SETTLE_W-1:0]  settle_q, settle_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [KEY_W-1:0]     key_code_q, key_code_d;
   logic [3:0]           key_value_q, key_value_d;
   logic [2:0]           sign_q, sign_d;

   logic [ROW_W-1:0]     row_sel;
   logic                 row_onehot;
   logic                 row_match;
   logic [COL_W-1:0]     col_next;
   logic [KEY_W-1:0]     dec_code;
   logic [3:0]           dec_value;
   logic [2:0]           dec_sign;

   // Multiple active rows on one column are indistinguishable from ghosting.
   assign row_onehot = (row_in != '0) && ((row_in & (row_in - 1'b1)) == '0);
   assign row_match  = row_onehot && (row_sel == row_idx_q);
   assign col_next   = (col_idx_q == COL_LAST) ? '0 : col_idx_q + 1'b1;

   always_comb begin
      row_sel = '0;
      for (int i = 0; i < ROWS; i++) begin
         if (row_in[i]) begin
            row_sel = ROW_W'(i);
         end
      end
   end

   keypad_decode #(
      .ROWS (ROWS),
      .COLS (COLS)
   ) u_decode (
      .col_idx     (col_idx_q),
      .row_idx     (row_idx_q),
      .key_code    (dec_code),
      .key_value   (dec_value),
      .is_sign_key (dec_sign)
   );

   always_comb begin
      state_d     = state_q;
      col_idx_d   = col_idx_q;
      row_idx_d   = row_idx_q;
      settle_d    = settle_q;
      cnt_d       = cnt_q;
      key_code_d  = key_code_q;
      key_value_d = key_value_q;
      sign_d      = sign_q;
      case (state_q)
         SCAN: begin
            if (settle_q == SETTLE_LAST) begin
               settle_d = '0;
               if (row_onehot) begin
                  state_d   = DEBOUNCE;
                  row_idx_d = row_sel;
                  cnt_d     = CNT_W'(1);
               end else begin
                  col_idx_d = col_next;
               end
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (cnt_q == DEB_TARGET) begin
               state_d     = PRESENT;
               cnt_d       = '0;
               key_code_d  = dec_code;
               key_value_d = dec_value;
               sign_d      = dec_sign;
            end else if (row_match) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               state_d   = SCAN;
               col_idx_d = col_next;
               settle_d  = '0;
               cnt_d     = '0;
            end
         end
         PRESENT: begin
            if (key_ready) begin
               state_d = WAIT_RELEASE;
               cnt_d   = '0;
            end
         end
         WAIT_RELEASE: begin
            if (row_in != '0) begin
               cnt_d = '0;
            end else if (cnt_q + 1'b1 == DEB_TARGET) begin
               state_d   = SCAN;
               col_idx_d = col_next;
               settle_d  = '0;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = SCAN;
         end
      endcase
   end

   // Strobe is registered so the pins never see decode glitches.
   genvar gi;
   generate
      for (gi = 0; gi < COLS; gi++) begin : g_col
         assign col_drive_d[gi] = (col_idx_d == COL_W'(gi));
      end
   endgenerate

   always_ff @(posedge slow_clk) begin
      if (rst) begin
         state_q     <= SCAN;
         col_idx_q   <= '0;
         col_drive_q <= COLS'(1);
         row_idx_q   <= '0;
         settle_q    <= '0;
         cnt_q       <= '0;
         key_code_q  <= '0;
         key_value_q <= '0;
         sign_q      <= '0;
      end else begin
         state_q     <= state_d;
         col_idx_q   <= col_idx_d;
         col_drive_q <= col_drive_d;
         row_idx_q   <= row_idx_d;
         settle_q    <= settle_d;
         cnt_q       <= cnt_d;
         key_code_q  <= key_code_d;
         key_value_q <= key_value_d;
         sign_q      <= sign_d;
      end
   end

   assign col_drive   = col_drive_q;
   assign key_valid   = (state_q == PRESENT);
   assign key_pressed = (state_q == PRESENT) || (state_q == WAIT_RELEASE);
   assign key_code    = key_code_q;
   assign key_value   = key_value_q;
   assign is_sign_key = sign_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a physical keypad model drives row_in
// from col_drive, and expectations come from scan-timing arithmetic and the key map.
`timescale 1ns/1ps
module tb_keypad_scanner;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int S    = 1;
   localparam int DS   = 4;

   logic       slow_clk = 1'b0;
   logic       rst;
   logic [3:0] row_in;
   logic [3:0] col_drive;
   logic       key_valid;
   logic       key_ready;
   logic [3:0] key_code;
   logic [3:0] key_value;
   logic [2:0] is_sign_key;
   logic       key_pressed;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int org_t  = 0;
   int org_c  = 0;

   bit         pressed  = 1'b0;
   int         key_c    = 0;
   int         key_r    = 0;
   bit         force_en = 1'b0;
   logic [3:0] force_val = '0;
   string      keymap [4] = '{"147*", "2580", "369#", "ABCD"};

   keypad_scanner #(
      .ROWS           (ROWS),
      .COLS           (COLS),
      .SETTLE_CYCLES  (S),
      .DEBOUNCE_SCANS (DS)
   ) dut (
      .slow_clk    (slow_clk),
      .rst         (rst),
      .row_in      (row_in),
      .col_drive   (col_drive),
      .key_valid   (key_valid),
      .key_ready   (key_ready),
      .key_code    (key_code),
      .key_value   (key_value),
      .is_sign_key (is_sign_key),
      .key_pressed (key_pressed)
   );

   always #5 slow_clk = ~slow_clk;
   always @(posedge slow_clk) cyc <= cyc + 1;

   // Physical keypad: the held key connects column key_c to row key_r.
   always_comb begin
      row_in = '0;
      if (force_en) row_in = force_val;
      else if (pressed && col_drive[key_c]) row_in = 4'(1 << key_r);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Column visible after edge e while scanning from (org_t, org_c).
   function automatic int exp_col(input int e);
      return (org_c + (e - org_t) / (S + 1)) % COLS;
   endfunction

   function automatic bit is_sample_edge(input int e);
      return (e > org_t) && (((e - org_t) % (S + 1)) == 0);
   endfunction

   function automatic int next_detect(input int c);
      int d = cyc + 1;
      for (int g = 0; g < 200; g++) begin
         if (is_sample_edge(d) && exp_col(d - 1) == c) break;
         d++;
      end
      return d;
   endfunction

   task automatic ref_decode(input int c, input int r, output int code,
                             output logic [3:0] v, output logic [2:0] s);
      string col_keys;
      byte   ch;
      col_keys = keymap[c];
      ch   = col_keys.getc(3 - r);
      code = c * ROWS + r;
      case (ch)
         "*":     begin v = 4'b0000; s = 3'b100; end
         "#":     begin v = 4'b0000; s = 3'b010; end
         "A":     begin v = 4'b1010; s = 3'b001; end
         "B":     begin v = 4'b1011; s = 3'b011; end
         "C":     begin v = 4'b1100; s = 3'b011; end
         "D":     begin v = 4'b1111; s = 3'b100; end
         default: begin v = 4'(ch - "0"); s = 3'b000; end
      endcase
   endtask

   task automatic tick();
      @(posedge slow_clk);
      @(negedge slow_clk);
   endtask

   task automatic tick_scan();
      key_ready = 1'($urandom_range(0, 1));
      tick();
      chk("scan_col", 32'(col_drive), 32'(1 << exp_col(cyc)));
      chk("scan_valid", 32'(key_valid), 0);
      chk("scan_pressed", 32'(key_pressed), 0);
   endtask

   task automatic do_key(input int c, input int r, input int ready_dly, input bit rel_early,
                         input int hold, input int glitch_k, input bit bounce);
      int d, a, z, g, done, rel_edge, guard, ecode;
      logic [3:0] ev;
      logic [2:0] es;
      ref_decode(c, r, ecode, ev, es);
      if (bounce) begin
         guard = 0;
         while (!(is_sample_edge(cyc + 1) && exp_col(cyc) == c) && guard < 100) begin
            tick_scan();
            guard++;
         end
         force_en = 1'b1; force_val = 4'(1 << r);
         tick();
         chk("bounce_frozen", 32'(col_drive), 32'(1 << c));
         force_val = '0;
         tick();
         org_t = cyc; org_c = (c + 1) % COLS;
         chk("bounce_resume", 32'(col_drive), 32'(1 << org_c));
         force_val = 4'(1 << r);
         tick_scan();
         force_en = 1'b0;
      end
      key_c = c; key_r = r; pressed = 1'b1;
      d = next_detect(c);
      while (cyc < d - 1) tick_scan();
      while (cyc < d + DS - 1) begin
         key_ready = 1'($urandom_range(0, 1));
         tick();
         chk("deb_col", 32'(col_drive), 32'(1 << c));
         chk("deb_valid", 32'(key_valid), 0);
      end
      key_ready = (ready_dly == 0);
      tick();
      chk("pres_valid", 32'(key_valid), 1);
      chk("pres_pressed", 32'(key_pressed), 1);
      chk("pres_code", 32'(key_code), 32'(ecode));
      chk("pres_value", 32'(key_value), 32'(ev));
      chk("pres_sign", 32'(is_sign_key), 32'(es));
      rel_edge = 0;
      for (int i = 0; i < ready_dly; i++) begin
         if (rel_early && i == 0) begin
            pressed = 1'b0;
            rel_edge = cyc + 1;
         end
         key_ready = 1'b0;
         tick();
         chk("bp_valid", 32'(key_valid), 1);
         chk("bp_value", 32'(key_value), 32'(ev));
         chk("bp_sign", 32'(is_sign_key), 32'(es));
         chk("bp_code", 32'(key_code), 32'(ecode));
      end
      key_ready = 1'b1;
      tick();
      a = cyc;
      chk("xfer_valid", 32'(key_valid), 0);
      chk("xfer_pressed", 32'(key_pressed), 1);
      if (rel_edge == 0) begin
         for (int i = 0; i < hold; i++) begin
            key_ready = 1'($urandom_range(0, 1));
            tick();
            chk("hold_valid", 32'(key_valid), 0);
            chk("hold_pressed", 32'(key_pressed), 1);
            chk("hold_col", 32'(col_drive), 32'(1 << c));
         end
         pressed = 1'b0;
         rel_edge = cyc + 1;
      end
      z = (rel_edge > a + 1) ? rel_edge : a + 1;
      if (glitch_k > 0) begin
         g = z + glitch_k;
         done = g + DS;
      end else begin
         g = -1;
         done = z + DS - 1;
      end
      force_val = 4'(1 << r);
      while (cyc < done) begin
         key_ready = 1'($urandom_range(0, 1));
         force_en = (cyc + 1 == g);
         tick();
         chk("rel_valid", 32'(key_valid), 0);
         chk("rel_pressed", 32'(key_pressed), (cyc < done) ? 1 : 0);
      end
      force_en = 1'b0;
      org_t = done; org_c = (c + 1) % COLS;
      chk("resume_col", 32'(col_drive), 32'(1 << org_c));
      chk("kept_code", 32'(key_code), 32'(ecode));
      chk("kept_value", 32'(key_value), 32'(ev));
   endtask

   initial begin
      int d;
      rst = 1'b1; key_ready = 1'b0;
      @(negedge slow_clk);
      tick(); tick();
      chk("rst_col", 32'(col_drive), 1);
      chk("rst_valid", 32'(key_valid), 0);
      chk("rst_code", 32'(key_code), 0);
      chk("rst_value", 32'(key_value), 0);
      chk("rst_sign", 32'(is_sign_key), 0);
      chk("rst_pressed", 32'(key_pressed), 0);
      rst = 1'b0; org_t = cyc; org_c = 0;
      for (int i = 0; i < 2 * COLS * (S + 1); i++) tick_scan();

      do_key(1, 2, 0, 1'b0, 5, 0, 1'b0);        // clean "5", held with no repeat
      do_key(3, 3, 0, 1'b0, 2, 0, 1'b1);        // bounce then "A"
      do_key(3, 0, 10, 1'b1, 0, 0, 1'b0);       // "D" under backpressure, released early
      do_key(0, 1, 2, 1'b0, 3, DS - 2, 1'b0);   // release glitch restarts release count

      force_en = 1'b1; force_val = 4'b0011;     // ghost pattern never yields a key
      for (int i = 0; i < 2 * COLS * (S + 1); i++) tick_scan();
      force_en = 1'b0;

      key_c = 2; key_r = 1; pressed = 1'b1;     // reset during debounce
      d = next_detect(2);
      while (cyc < d - 1) tick_scan();
      tick(); tick();
      chk("mid_deb_col", 32'(col_drive), 32'(1 << 2));
      rst = 1'b1; pressed = 1'b0;
      tick();
      chk("mid_rst_col", 32'(col_drive), 1);
      chk("mid_rst_valid", 32'(key_valid), 0);
      chk("mid_rst_pressed", 32'(key_pressed), 0);
      chk("mid_rst_code", 32'(key_code), 0);
      rst = 1'b0; org_t = cyc; org_c = 0;
      for (int i = 0; i < 3 * COLS * (S + 1); i++) tick_scan();

      for (int e = 0; e < 16; e++) begin
         int idle;
         idle = $urandom_range(0, 5);
         for (int i = 0; i < idle; i++) tick_scan();
         do_key($urandom_range(0, COLS - 1), $urandom_range(0, ROWS - 1),
                $urandom_range(0, 6), 1'($urandom_range(0, 1)), $urandom_range(0, 4),
                $urandom_range(0, DS - 1), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
